// File: rtl/tft_arb_pkg.sv
// -----------------------------------------------------------------------------
// tft_arb_pkg
// Shared definitions for the TFT SPI bus arbiter: FSM state encoding and the
// arbitration mode constants. Imported by tft_arb_picker and tft_bus_arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package tft_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_GAP        = 2'd3
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/tft_arb_picker.sv
// -----------------------------------------------------------------------------
// tft_arb_picker
// Combinational winner selection over the eligible request vector.
//   ARB_MODE = ARB_FIXED : lowest eligible index wins, ptr ignored.
//   ARB_MODE = ARB_RR    : first eligible index at or after ptr, wrapping.
// Ports:
//   eligible  in   N_CH   masked request vector
//   ptr       in   ID_W   round-robin start index
//   win_id    out  ID_W   winning index (0 when nothing eligible)
//   win_valid out  1      at least one channel eligible
// -----------------------------------------------------------------------------
module tft_arb_picker
  import tft_arb_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int ID_W     = 2
) (
  input  logic [N_CH-1:0] eligible,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] win_id,
  output logic            win_valid
);

  always_comb begin
    int sum;
    logic [ID_W-1:0] idx;
    sum       = 0;
    idx       = '0;
    win_id    = '0;
    win_valid = |eligible;
    // Scan from the farthest candidate down to the nearest so the nearest
    // eligible one is the last to write win_id.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ARB_MODE == ARB_RR) begin
        sum = int'(ptr) + k;
        if (sum >= N_CH) sum = sum - N_CH;
      end else begin
        sum = k;
      end
      idx = ID_W'(sum);
      if (eligible[idx]) win_id = idx;
    end
  end

endmodule

// File: rtl/tft_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tft_bus_arbiter
// N-channel arbiter in front of tft_spi. Drawer clients request the SPI byte
// stream; one winner gets a registered one-hot enable and its data/dc/transmit
// are routed to tft_spi. Fixed-priority or round-robin selection; optional
// init gating keeps channel 0 alone on the bus until it first completes.
//
// Optional build macro: TFT_ARB_TIMEOUT_EN
//   defined   : grant watchdog aborts a grant after TIMEOUT_CYC cycles and
//               pulses timeout_err for one clock.
//   undefined : grants are held indefinitely, timeout_err is tied 0.
//
// Ports:
//   clk             in   1             system clock
//   rst             in   1             asynchronous active-low reset
//   req             in   N_CH          client request levels
//   client_busy     in   N_CH          client busy flags
//   client_data     in   N_CH*DATA_W   client i byte at [i*DATA_W +: DATA_W]
//   client_dc       in   N_CH          client data/command selects
//   client_transmit in   N_CH          client transmit strobes
//   enable          out  N_CH          one-hot grant (registered)
//   spi_data        out  DATA_W        granted client's byte, else 0
//   spi_dc          out  1             granted client's dc, else 0
//   spi_transmit    out  1             granted client's transmit, else 0
//   spi_busy        in   1             tft_spi busy
//   grant_id        out  $clog2(N_CH)  index of current or last grant
//   init_done       out  1             sticky: ch0 completed once
//   timeout_err     out  1             one-cycle pulse on watchdog abort
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | no grant; pick a winner from the eligible set
// WAIT_START  | enable asserted, waiting for the owner to raise busy
// ACTIVE      | owner running; done when owner and tft_spi both idle
// GAP         | enable low for one clock before the next decision
// -----------------------------------------------------------------------------
module tft_bus_arbiter
  import tft_arb_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 8,
  parameter int ARB_MODE    = ARB_FIXED,
  parameter int INIT_GATE   = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH-1:0]           client_busy,
  input  logic [N_CH*DATA_W-1:0]    client_data,
  input  logic [N_CH-1:0]           client_dc,
  input  logic [N_CH-1:0]           client_transmit,
  output logic [N_CH-1:0]           enable,
  output logic [DATA_W-1:0]         spi_data,
  output logic                      spi_dc,
  output logic                      spi_transmit,
  input  logic                      spi_busy,
  output logic [$clog2(N_CH)-1:0]   grant_id,
  output logic                      init_done,
  output logic                      timeout_err
);

  localparam int ID_W = $clog2(N_CH);

  if (N_CH < 2 || N_CH > 8) begin : g_bad_n_ch
    $error("tft_bus_arbiter: N_CH must be 2..8");
  end
  if (ARB_MODE != ARB_FIXED && ARB_MODE != ARB_RR) begin : g_bad_mode
    $error("tft_bus_arbiter: ARB_MODE must be 0 or 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("tft_bus_arbiter: TIMEOUT_CYC must be at least 1");
  end

  arb_state_e        state_q, state_d;
  logic [N_CH-1:0]   enable_q, enable_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              init_done_q, init_done_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic [N_CH-1:0]   eligible;
  logic [ID_W-1:0]   win_id;
  logic              win_valid;
  logic              grant_busy;
  logic              grant_req;
  logic              enter_gap;

  // Until ch0 has completed once, only its request is visible to the picker.
  assign eligible = (INIT_GATE != 0 && !init_done_q)
                  ? (req & {{(N_CH-1){1'b0}}, 1'b1})
                  : req;

  assign grant_busy = client_busy[grant_id_q];
  assign grant_req  = req[grant_id_q];

  tft_arb_picker #(
    .N_CH     (N_CH),
    .ARB_MODE (ARB_MODE),
    .ID_W     (ID_W)
  ) u_picker (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

`ifdef TFT_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          timeout_err_q, timeout_err_d;
  logic          tmr_expired;

  // Reloaded while not granted; counts down once per granted cycle, so the
  // terminal count is reached after exactly TIMEOUT_CYC cycles of enable.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == ST_WAIT_START || state_q == ST_ACTIVE) begin
      if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
    end else begin
      tmr_d = TMR_LOAD;
    end
  end

  assign tmr_expired = (tmr_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q         <= TMR_LOAD;
      timeout_err_q <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    grant_id_d  = grant_id_q;
    init_done_d = init_done_q;
    ptr_d       = ptr_q;
    enter_gap   = 1'b0;
`ifdef TFT_ARB_TIMEOUT_EN
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          enable_d         = '0;
          enable_d[win_id] = 1'b1;
          grant_id_d       = win_id;
          state_d          = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
`ifdef TFT_ARB_TIMEOUT_EN
        if (tmr_expired) begin
          enter_gap     = 1'b1;
          timeout_err_d = 1'b1;
        end else
`endif
        if (grant_busy) begin
          state_d = ST_ACTIVE;
        end else if (!grant_req) begin
          // Owner withdrew before starting: release without completion.
          enter_gap = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!grant_busy && !spi_busy) begin
          enter_gap = 1'b1;
          if (grant_id_q == '0) init_done_d = 1'b1;
        end
`ifdef TFT_ARB_TIMEOUT_EN
        else if (tmr_expired) begin
          enter_gap     = 1'b1;
          timeout_err_d = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        enable_d = '0;
      end
    endcase

    if (enter_gap) begin
      state_d  = ST_GAP;
      enable_d = '0;
      if (ARB_MODE == ARB_RR) begin
        ptr_d = (grant_id_q == ID_W'(N_CH - 1)) ? '0 : grant_id_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      enable_q    <= '0;
      grant_id_q  <= '0;
      init_done_q <= (INIT_GATE == 0);
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      grant_id_q  <= grant_id_d;
      init_done_q <= init_done_d;
      ptr_q       <= ptr_d;
    end
  end

  // enable_q is one-hot or zero, so an OR-mux yields all zeros when idle.
  always_comb begin
    spi_data     = '0;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (enable_q[i]) begin
        spi_data     = client_data[i*DATA_W +: DATA_W];
        spi_dc       = client_dc[i];
        spi_transmit = client_transmit[i];
      end
    end
  end

  assign enable    = enable_q;
  assign grant_id  = grant_id_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tft_bus_arbiter
// Two arbiters (u_fix: fixed priority, u_rr: round-robin), both N_CH=4,
// INIT_GATE=1, TIMEOUT_CYC=16. Stimulus pushes the expected winner of each
// upcoming grant into a per-instance queue; the monitor pops on every rising
// enable and checks enable, grant_id, the SPI mux and the minimum gap.
// -----------------------------------------------------------------------------
module tb_tft_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b [2];
  logic [3:0]  req   [2];
  logic [3:0]  cbusy [2];
  logic        sbusy [2];
  logic [31:0] cdata;
  logic [3:0]  cdc;
  logic [3:0]  ctx;

  logic [3:0]  en    [2];
  logic [7:0]  sdata [2];
  logic        sdc   [2];
  logic        stx   [2];
  logic [1:0]  gid   [2];
  logic        idone [2];
  logic        terr  [2];

  tft_bus_arbiter #(.N_CH(4), .DATA_W(8), .ARB_MODE(0), .INIT_GATE(1), .TIMEOUT_CYC(16)) u_fix (
    .clk(clk), .rst(rst_b[0]), .req(req[0]), .client_busy(cbusy[0]),
    .client_data(cdata), .client_dc(cdc), .client_transmit(ctx),
    .enable(en[0]), .spi_data(sdata[0]), .spi_dc(sdc[0]), .spi_transmit(stx[0]),
    .spi_busy(sbusy[0]), .grant_id(gid[0]), .init_done(idone[0]), .timeout_err(terr[0])
  );

  tft_bus_arbiter #(.N_CH(4), .DATA_W(8), .ARB_MODE(1), .INIT_GATE(1), .TIMEOUT_CYC(16)) u_rr (
    .clk(clk), .rst(rst_b[1]), .req(req[1]), .client_busy(cbusy[1]),
    .client_data(cdata), .client_dc(cdc), .client_transmit(ctx),
    .enable(en[1]), .spi_data(sdata[1]), .spi_dc(sdc[1]), .spi_transmit(stx[1]),
    .spi_busy(sbusy[1]), .grant_id(gid[1]), .init_done(idone[1]), .timeout_err(terr[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int         q0[$];
  int         q1[$];
  logic [3:0] prev_en  [2];
  int         low_cnt  [2];
  int         last_gap [2];
  int         n_gr     [2];

  task automatic mon(input int m);
    int ch;
    bit have;
    ch   = 0;
    have = 1'b0;
    if (!rst_b[m]) begin
      prev_en[m] = '0;
      low_cnt[m] = 0;
      n_gr[m]    = 0;
      return;
    end
    if (en[m] != '0 && prev_en[m] == '0) begin
      if (m == 0 && q0.size() > 0) begin ch = q0.pop_front(); have = 1'b1; end
      if (m == 1 && q1.size() > 0) begin ch = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        chk($sformatf("u%0d unexpected_grant", m), {28'b0, en[m]}, 32'h0);
      end else begin
        chk($sformatf("u%0d grant_enable", m), {28'b0, en[m]}, 32'(1 << ch));
        chk($sformatf("u%0d grant_id", m), {30'b0, gid[m]}, 32'(ch));
        chk($sformatf("u%0d spi_data", m), {24'b0, sdata[m]}, {24'b0, cdata[ch*8 +: 8]});
        chk($sformatf("u%0d spi_dc", m), {31'b0, sdc[m]}, {31'b0, cdc[ch]});
        chk($sformatf("u%0d spi_transmit", m), {31'b0, stx[m]}, {31'b0, ctx[ch]});
      end
      if (n_gr[m] > 0) chk($sformatf("u%0d gap_min2", m), 32'(low_cnt[m] >= 2), 32'd1);
      last_gap[m] = low_cnt[m];
      n_gr[m]     = n_gr[m] + 1;
      low_cnt[m]  = 0;
    end
    if (en[m] == '0) low_cnt[m] = low_cnt[m] + 1;
    else if (!$onehot(en[m])) chk($sformatf("u%0d onehot", m), {28'b0, en[m]}, 32'h0);
    prev_en[m] = en[m];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_grant(input int m, output int g);
    g = -1;
    for (int k = 0; k < 60 && en[m] == '0; k++) @(negedge clk);
    if (en[m] == '0) begin
      chk($sformatf("u%0d grant_wait", m), 32'(en[m] != '0), 32'd1);
    end else begin
      for (int i = 0; i < 4; i++) if (en[m][i]) g = i;
    end
  endtask

  task automatic wait_low(input int m);
    for (int k = 0; k < 60 && en[m] != '0; k++) @(negedge clk);
    if (en[m] != '0) chk($sformatf("u%0d release_wait", m), {28'b0, en[m]}, 32'h0);
  endtask

  task automatic serve(input int m, input int dur);
    int g;
    wait_grant(m, g);
    if (g < 0) return;
    cbusy[m][g] = 1'b1;
    repeat (dur) @(negedge clk);
    cbusy[m][g] = 1'b0;
    wait_low(m);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int g;
    int cnt;
    for (int m = 0; m < 2; m++) begin
      rst_b[m] = 1'b0; req[m] = '0; cbusy[m] = '0; sbusy[m] = 1'b0;
    end
    cdata = 32'hA3A2_A1A0;
    cdc   = 4'b0110;
    ctx   = 4'b1001;
    repeat (2) @(negedge clk);

    for (int m = 0; m < 2; m++) begin
      chk($sformatf("u%0d rst_enable", m), {28'b0, en[m]}, 32'h0);
      chk($sformatf("u%0d rst_grant_id", m), {30'b0, gid[m]}, 32'h0);
      chk($sformatf("u%0d rst_init_done", m), {31'b0, idone[m]}, 32'h0);
      chk($sformatf("u%0d rst_timeout_err", m), {31'b0, terr[m]}, 32'h0);
      chk($sformatf("u%0d rst_spi", m), {22'b0, sdata[m], sdc[m], stx[m]}, 32'h0);
    end

    // Init gating: all request, only ch0 may go first.
    q0.push_back(0);
    req[0]   = 4'b1111;
    rst_b[0] = 1'b1;
    rst_b[1] = 1'b1;
    wait_grant(0, g);
    chk("u0 init_pending", {31'b0, idone[0]}, 32'h0);
    if (g >= 0) begin
      cbusy[0][g] = 1'b1;
      repeat (3) @(negedge clk);
      cbusy[0][g] = 1'b0;
    end
    wait_low(0);
    chk("u0 init_done_set", {31'b0, idone[0]}, 32'h1);

    // Fixed priority, req=1010 held: ch1 every time, ch3 starves.
    req[0] = 4'b1010;
    q0.push_back(1); q0.push_back(1); q0.push_back(1);
    serve(0, 3);
    serve(0, 2);
    chk("u0 gap_exact_a", 32'(last_gap[0]), 32'd2);
    serve(0, 2);
    chk("u0 gap_exact_b", 32'(last_gap[0]), 32'd2);
    req[0] = '0;

    // Completion waits for tft_spi to go idle.
    req[0] = 4'b0100;
    q0.push_back(2);
    wait_grant(0, g);
    cbusy[0][2] = 1'b1;
    sbusy[0]    = 1'b1;
    repeat (2) @(negedge clk);
    cbusy[0][2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("u0 hold_on_spi_busy", {28'b0, en[0]}, 32'h4);
    sbusy[0] = 1'b0;
    req[0]   = '0;
    @(negedge clk);
    chk("u0 release_after_spi", {28'b0, en[0]}, 32'h0);

`ifdef TFT_ARB_TIMEOUT_EN
    // Watchdog: ch3 never releases busy; abort after 16 granted cycles.
    req[0] = 4'b1000;
    q0.push_back(3);
    wait_grant(0, g);
    cbusy[0][3] = 1'b1;
    req[0]      = 4'b1010;
    q0.push_back(1);
    cnt = 0;
    while (en[0] != '0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("u0 timeout_cycles", 32'(cnt), 32'd16);
    chk("u0 timeout_err_pulse", {31'b0, terr[0]}, 32'h1);
    @(negedge clk);
    chk("u0 timeout_err_clear", {31'b0, terr[0]}, 32'h0);
    cbusy[0][3] = 1'b0;
    serve(0, 2);
    req[0] = '0;
`else
    cnt = 0;
    chk("u0 timeout_err_tied", {31'b0, terr[0]}, 32'h0);
`endif

    // RR: cancel ch0 before it starts; init_done must stay clear.
    q1.push_back(0);
    req[1] = 4'b0001;
    wait_grant(1, g);
    req[1] = '0;
    @(negedge clk);
    chk("u1 cancel_drop", {28'b0, en[1]}, 32'h0);
    chk("u1 cancel_no_init", {31'b0, idone[1]}, 32'h0);

    // RR, all requesting: gated ch0 first, then 1,2,3 and wrap to 0.
    req[1] = 4'b1111;
    q1.push_back(0); q1.push_back(1); q1.push_back(2); q1.push_back(3); q1.push_back(0);
    for (int i = 0; i < 5; i++) serve(1, 3);
    req[1] = '0;
    chk("u1 init_done_set", {31'b0, idone[1]}, 32'h1);

    // Cancel of ch1 still advances the pointer: next pick from 1110 is ch2.
    q1.push_back(1);
    req[1] = 4'b0010;
    wait_grant(1, g);
    req[1] = '0;
    @(negedge clk);
    chk("u1 cancel1_drop", {28'b0, en[1]}, 32'h0);
    req[1] = 4'b1110;
    q1.push_back(2);
    serve(1, 2);
    req[1] = '0;

    // Reset in the middle of ACTIVE drops everything at once.
    q1.push_back(2);
    req[1] = 4'b0100;
    wait_grant(1, g);
    cbusy[1][2] = 1'b1;
    repeat (3) @(negedge clk);
    rst_b[1] = 1'b0;
    #1;
    chk("u1 rst_mid_enable", {28'b0, en[1]}, 32'h0);
    chk("u1 rst_mid_grant_id", {30'b0, gid[1]}, 32'h0);
    chk("u1 rst_mid_init_done", {31'b0, idone[1]}, 32'h0);
    chk("u1 rst_mid_spi_data", {24'b0, sdata[1]}, 32'h0);
    cbusy[1] = '0;
    req[1]   = '0;
    @(negedge clk);
    rst_b[1] = 1'b1;

    repeat (5) @(negedge clk);
    chk("u0 queue_drained", 32'(q0.size()), 32'd0);
    chk("u1 queue_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
